// File: rtl/axi_write_arbiter_rr.sv
// AXI write-path arbiter: picks one of NUM_MASTERS AW requesters (round-robin or
// fixed priority), decodes its address to a slave (or the default decode-error
// slave) and holds that master/slave route through the AW, W and B phases.
module axi_write_arbiter_rr #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int RR_MODE     = 1,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {
        32'h0003_0000, 32'h0010_0000, 32'h2000_0000, 32'h1001_0000,
        32'h1000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_MASTERS-1:0]            AWVALID_M,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] AWADDR_M,
    input  logic [NUM_MASTERS-1:0]            WVALID_M,
    input  logic [NUM_MASTERS-1:0]            WLAST_M,
    input  logic [NUM_MASTERS-1:0]            BREADY_M,
    input  logic [NUM_SLAVES:0]               AWREADY_S,
    input  logic [NUM_SLAVES:0]               WREADY_S,
    input  logic [NUM_SLAVES:0]               BVALID_S,
    output logic [NUM_MASTERS-1:0]            grant_m,
    output logic [NUM_SLAVES:0]               grant_s,
    output logic                              aw_en,
    output logic                              w_en,
    output logic                              b_en,
    output logic                              busy
);

    localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SIDX_W = $clog2(NUM_SLAVES + 1);
    localparam int NSP    = NUM_SLAVES + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;

    state_t            state, state_nxt;
    logic [MIDX_W-1:0] gidx, gidx_nxt;
    logic [MIDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [SIDX_W-1:0] sidx, sidx_nxt;
    logic              aw_done, aw_done_nxt;
    logic              w_done, w_done_nxt;
    logic              aw_hs, w_hs, b_hs;

    // First requester at or after ptr, searching upward with wrap. With ptr
    // pinned at 0 this is plain lowest-index priority.
    function automatic logic [MIDX_W-1:0] pick_master(
        input logic [NUM_MASTERS-1:0] req,
        input logic [MIDX_W-1:0]      ptr
    );
        logic [MIDX_W-1:0] win;
        logic              found;
        int                idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                win   = MIDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Address of master idx, selected with constant slices only.
    function automatic logic [ADDR_WIDTH-1:0] master_addr(
        input logic [NUM_MASTERS*ADDR_WIDTH-1:0] addrs,
        input logic [MIDX_W-1:0]                 idx
    );
        logic [ADDR_WIDTH-1:0] a;
        a = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (MIDX_W'(i) == idx) a = addrs[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        return a;
    endfunction

    // Lowest matching slave wins; no match routes to the default slave.
    function automatic logic [SIDX_W-1:0] decode_slave(
        input logic [ADDR_WIDTH-1:0] addr
    );
        logic [SIDX_W-1:0] slv;
        slv = SIDX_W'(NUM_SLAVES);
        for (int j = NUM_SLAVES - 1; j >= 0; j--) begin
            if ((addr & SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH])
                slv = SIDX_W'(j);
        end
        return slv;
    endfunction

    // Next-state, route selection, phase-completion flags and pointer update.
    always_comb begin
        state_nxt   = state;
        gidx_nxt    = gidx;
        sidx_nxt    = sidx;
        rr_ptr_nxt  = rr_ptr;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        aw_hs       = AWVALID_M[gidx] & AWREADY_S[sidx];
        w_hs        = WVALID_M[gidx] & WLAST_M[gidx] & WREADY_S[sidx];
        b_hs        = BVALID_S[sidx] & BREADY_M[gidx];
        case (state)
            ST_IDLE: begin
                if (|AWVALID_M) begin
                    gidx_nxt  = pick_master(AWVALID_M, rr_ptr);
                    sidx_nxt  = decode_slave(master_addr(AWADDR_M, gidx_nxt));
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // AW and last W beat may complete in either order or together.
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    state_nxt   = ST_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_nxt = ST_IDLE;
                    if (RR_MODE != 0)
                        rr_ptr_nxt = (gidx == MIDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, route and flags; select vectors and enables registered alongside.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= ST_IDLE;
            gidx    <= '0;
            sidx    <= '0;
            rr_ptr  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            grant_m <= '0;
            grant_s <= '0;
            aw_en   <= 1'b0;
            w_en    <= 1'b0;
            b_en    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            gidx    <= gidx_nxt;
            sidx    <= sidx_nxt;
            rr_ptr  <= rr_ptr_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            grant_m <= (state_nxt != ST_IDLE) ? (NUM_MASTERS'(1) << gidx_nxt) : '0;
            grant_s <= (state_nxt != ST_IDLE) ? (NSP'(1) << sidx_nxt) : '0;
            aw_en   <= (state_nxt == ST_ADDR);
            w_en    <= (state_nxt == ST_ADDR);
            b_en    <= (state_nxt == ST_RESP);
            busy    <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter_rr.sv
// Bench for axi_write_arbiter_rr: a round-robin instance and a fixed-priority
// instance share all inputs; expectations come from a transaction-level model.
module tb_axi_write_arbiter_rr;

    localparam int NM = 3;
    localparam int NS = 8;
    localparam int AW = 32;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [NM-1:0]     AWVALID_M, WVALID_M, WLAST_M, BREADY_M;
    logic [NM*AW-1:0]  AWADDR_M;
    logic [NS:0]       AWREADY_S, WREADY_S, BVALID_S;

    logic [NM-1:0]     grant_m, fp_grant_m;
    logic [NS:0]       grant_s, fp_grant_s;
    logic              aw_en, w_en, b_en, busy;
    logic              fp_aw_en, fp_w_en, fp_b_en, fp_busy;

    logic [15:0]       obs_rr, obs_fp;
    assign obs_rr = {grant_m, grant_s, aw_en, w_en, b_en, busy};
    assign obs_fp = {fp_grant_m, fp_grant_s, fp_aw_en, fp_w_en, fp_b_en, fp_busy};

    int errors = 0;
    int checks = 0;
    int ptr_model = 0;

    logic [31:0] base_t [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000,
                                 32'h1001_0000, 32'h2000_0000, 32'h0010_0000, 32'h0003_0000};
    logic [31:0] mask_t [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                 32'hFFFF_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    always #5 ACLK = ~ACLK;

    axi_write_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .RR_MODE(1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .AWVALID_M(AWVALID_M), .AWADDR_M(AWADDR_M),
        .WVALID_M(WVALID_M), .WLAST_M(WLAST_M), .BREADY_M(BREADY_M),
        .AWREADY_S(AWREADY_S), .WREADY_S(WREADY_S), .BVALID_S(BVALID_S),
        .grant_m(grant_m), .grant_s(grant_s), .aw_en(aw_en), .w_en(w_en),
        .b_en(b_en), .busy(busy));

    axi_write_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .RR_MODE(0)) dut_fp (
        .ACLK(ACLK), .ARESETn(ARESETn), .AWVALID_M(AWVALID_M), .AWADDR_M(AWADDR_M),
        .WVALID_M(WVALID_M), .WLAST_M(WLAST_M), .BREADY_M(BREADY_M),
        .AWREADY_S(AWREADY_S), .WREADY_S(WREADY_S), .BVALID_S(BVALID_S),
        .grant_m(fp_grant_m), .grant_s(fp_grant_s), .aw_en(fp_aw_en), .w_en(fp_w_en),
        .b_en(fp_b_en), .busy(fp_busy));

    // Expected output vector: st 0 = idle, 1 = address/data phase, 2 = response phase.
    function automatic logic [15:0] expv(input int m, input int s, input int st);
        logic [15:0] v;
        v = '0;
        if (st != 0) begin
            v[13 + m] = 1'b1;
            v[4 + s]  = 1'b1;
            v[3]      = (st == 1);
            v[2]      = (st == 1);
            v[1]      = (st == 2);
            v[0]      = 1'b1;
        end
        return v;
    endfunction

    function automatic int model_slave(input logic [31:0] addr);
        for (int j = 0; j < NS; j++)
            if ((addr & mask_t[j]) == base_t[j]) return j;
        return NS;
    endfunction

    function automatic int model_winner(input logic [NM-1:0] req, input int ptr);
        for (int k = 0; k < NM; k++)
            if (req[(ptr + k) % NM]) return (ptr + k) % NM;
        return -1;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clr_inputs();
        AWVALID_M = '0; WVALID_M = '0; WLAST_M = '0; BREADY_M = '0;
        AWREADY_S = '0; WREADY_S = '0; BVALID_S = '0;
    endtask

    task automatic start_txn(input int m, input logic [31:0] a);
        AWADDR_M[m*AW +: AW] = a;
        AWVALID_M[m] = 1'b1;
        tick();
    endtask

    task automatic both_hs(input int m, input int s);
        AWREADY_S[s] = 1'b1; WREADY_S[s] = 1'b1; WVALID_M[m] = 1'b1; WLAST_M[m] = 1'b1;
        tick();
        AWVALID_M[m] = 1'b0; AWREADY_S = '0; WREADY_S = '0; WVALID_M[m] = 1'b0; WLAST_M[m] = 1'b0;
    endtask

    task automatic do_b(input int m, input int s);
        BVALID_S[s] = 1'b1; BREADY_M[m] = 1'b1;
        tick();
        BVALID_S = '0; BREADY_M = '0;
        ptr_model = (m + 1) % NM;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        clr_inputs();
        AWADDR_M = '0;
        tick();
        checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL reset_rr: got %h expected %h", obs_rr, 16'h0); end
        checks++; if (obs_fp !== 16'h0) begin errors++; $display("FAIL reset_fp: got %h expected %h", obs_fp, 16'h0); end
        ARESETn = 1'b1;
        ptr_model = 0;
        tick();
        checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL idle_no_req: got %h expected %h", obs_rr, 16'h0); end
    endtask

    task automatic test_reset_mid_resp();
        start_txn(0, 32'h0000_0000); both_hs(0, 0); do_b(0, 0);
        start_txn(1, 32'h0001_0000);
        checks++; if (obs_rr !== expv(1, 1, 1)) begin errors++; $display("FAIL pre_rst_addr: got %h expected %h", obs_rr, expv(1, 1, 1)); end
        both_hs(1, 1);
        checks++; if (obs_rr !== expv(1, 1, 2)) begin errors++; $display("FAIL pre_rst_resp: got %h expected %h", obs_rr, expv(1, 1, 2)); end
        ARESETn = 1'b0;
        #1;
        checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL async_rst_rr: got %h expected %h", obs_rr, 16'h0); end
        checks++; if (obs_fp !== 16'h0) begin errors++; $display("FAIL async_rst_fp: got %h expected %h", obs_fp, 16'h0); end
        #1;
        ARESETn = 1'b1;
        ptr_model = 0;
        AWADDR_M[0 +: AW] = 32'h0000_0000;
        AWADDR_M[AW +: AW] = 32'h0001_0000;
        AWVALID_M = 3'b011;
        tick();
        // pointer was 1 before reset; after reset M0 must win
        checks++; if (obs_rr !== expv(0, 0, 1)) begin errors++; $display("FAIL post_rst_grant: got %h expected %h", obs_rr, expv(0, 0, 1)); end
        both_hs(0, 0);
        do_b(0, 0);
        AWVALID_M = '0;
        tick();
    endtask

    task automatic test_single_write();
        start_txn(1, 32'h0002_0040);
        checks++; if (obs_rr !== expv(1, 2, 1)) begin errors++; $display("FAIL single_addr: got %h expected %h", obs_rr, expv(1, 2, 1)); end
        both_hs(1, 2);
        checks++; if (obs_rr !== expv(1, 2, 2)) begin errors++; $display("FAIL single_resp: got %h expected %h", obs_rr, expv(1, 2, 2)); end
        do_b(1, 2);
        checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL single_idle: got %h expected %h", obs_rr, 16'h0); end
    endtask

    task automatic test_decode();
        logic [31:0] addrs [4] = '{32'h2010_0000, 32'h0010_0004, 32'h0003_0000, 32'h4000_0000};
        int          slvs  [4] = '{5, 6, 7, 8};
        for (int k = 0; k < 4; k++) begin
            start_txn(k % NM, addrs[k]);
            checks++; if (obs_rr !== expv(k % NM, slvs[k], 1)) begin errors++; $display("FAIL decode_addr %h: got %h expected %h", addrs[k], obs_rr, expv(k % NM, slvs[k], 1)); end
            both_hs(k % NM, slvs[k]);
            checks++; if (obs_rr !== expv(k % NM, slvs[k], 2)) begin errors++; $display("FAIL decode_resp %h: got %h expected %h", addrs[k], obs_rr, expv(k % NM, slvs[k], 2)); end
            do_b(k % NM, slvs[k]);
            checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL decode_idle %h: got %h expected %h", addrs[k], obs_rr, 16'h0); end
        end
    endtask

    task automatic test_w_order();
        // last W beat two cycles ahead of the AW handshake
        start_txn(2, 32'h1000_0000);
        checks++; if (obs_rr !== expv(2, 3, 1)) begin errors++; $display("FAIL wfirst_grant: got %h expected %h", obs_rr, expv(2, 3, 1)); end
        WVALID_M[2] = 1'b1; WLAST_M[2] = 1'b1; WREADY_S[3] = 1'b1;
        tick();
        WVALID_M = '0; WLAST_M = '0; WREADY_S = '0;
        checks++; if (obs_rr !== expv(2, 3, 1)) begin errors++; $display("FAIL wfirst_hold1: got %h expected %h", obs_rr, expv(2, 3, 1)); end
        tick();
        checks++; if (obs_rr !== expv(2, 3, 1)) begin errors++; $display("FAIL wfirst_hold2: got %h expected %h", obs_rr, expv(2, 3, 1)); end
        AWREADY_S[3] = 1'b1;
        tick();
        AWVALID_M = '0; AWREADY_S = '0;
        checks++; if (obs_rr !== expv(2, 3, 2)) begin errors++; $display("FAIL wfirst_resp: got %h expected %h", obs_rr, expv(2, 3, 2)); end
        do_b(2, 3);
        // AW first, then a non-last beat, then the last beat
        start_txn(0, 32'h0001_0000);
        AWREADY_S[1] = 1'b1;
        tick();
        AWVALID_M = '0; AWREADY_S = '0;
        checks++; if (obs_rr !== expv(0, 1, 1)) begin errors++; $display("FAIL awfirst_hold1: got %h expected %h", obs_rr, expv(0, 1, 1)); end
        WVALID_M[0] = 1'b1; WREADY_S[1] = 1'b1;
        tick();
        checks++; if (obs_rr !== expv(0, 1, 1)) begin errors++; $display("FAIL awfirst_notlast: got %h expected %h", obs_rr, expv(0, 1, 1)); end
        WLAST_M[0] = 1'b1;
        tick();
        WVALID_M = '0; WLAST_M = '0; WREADY_S = '0;
        checks++; if (obs_rr !== expv(0, 1, 2)) begin errors++; $display("FAIL awfirst_resp: got %h expected %h", obs_rr, expv(0, 1, 2)); end
        do_b(0, 1);
    endtask

    task automatic test_stalled_b();
        int g;
        start_txn(0, 32'h0000_0000);
        both_hs(0, 0);
        AWADDR_M[AW +: AW]   = 32'h1001_0000;
        AWADDR_M[2*AW +: AW] = 32'h2000_0000;
        AWVALID_M = 3'b110;
        BVALID_S[0] = 1'b1;
        BREADY_M = 3'b010;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (obs_rr !== expv(0, 0, 2)) begin errors++; $display("FAIL stall_hold c%0d: got %h expected %h", c, obs_rr, expv(0, 0, 2)); end
        end
        BREADY_M = 3'b001;
        tick();
        BVALID_S = '0; BREADY_M = '0;
        ptr_model = 1;
        checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL stall_release: got %h expected %h", obs_rr, 16'h0); end
        tick();
        g = model_winner(3'b110, ptr_model);
        checks++; if (obs_rr !== expv(g, model_slave(AWADDR_M[g*AW +: AW]), 1)) begin errors++; $display("FAIL stall_next: got %h expected %h", obs_rr, expv(g, model_slave(AWADDR_M[g*AW +: AW]), 1)); end
        both_hs(g, model_slave(AWADDR_M[g*AW +: AW]));
        do_b(g, model_slave(AWADDR_M[g*AW +: AW]));
        AWVALID_M = '0;
        tick();
    endtask

    task automatic test_fairness();
        int g;
        ARESETn = 1'b0;
        clr_inputs();
        AWADDR_M = '0;
        tick();
        ARESETn = 1'b1;
        ptr_model = 0;
        AWVALID_M = '1; WVALID_M = '1; WLAST_M = '1; BREADY_M = '1;
        AWREADY_S = '1; WREADY_S = '1; BVALID_S = '1;
        for (int n = 0; n < 4; n++) begin
            tick();
            g = model_winner(3'b111, ptr_model);
            checks++; if (obs_rr !== expv(g, 0, 1)) begin errors++; $display("FAIL rr_order n%0d: got %h expected %h", n, obs_rr, expv(g, 0, 1)); end
            checks++; if (obs_fp !== expv(0, 0, 1)) begin errors++; $display("FAIL fixed_order n%0d: got %h expected %h", n, obs_fp, expv(0, 0, 1)); end
            ptr_model = (g + 1) % NM;
            tick();
            tick();
        end
        clr_inputs();
        tick();
        checks++; if (obs_rr !== 16'h0) begin errors++; $display("FAIL fair_idle_rr: got %h expected %h", obs_rr, 16'h0); end
        checks++; if (obs_fp !== 16'h0) begin errors++; $display("FAIL fair_idle_fp: got %h expected %h", obs_fp, 16'h0); end
    endtask

    task automatic test_random();
        logic [31:0]   tbl [6] = '{32'h0000_1234, 32'h0002_0040, 32'h1001_8000, 32'h20AB_0000, 32'h0003_FFFC, 32'h8000_0000};
        logic [31:0]   a [NM];
        logic [NM-1:0] req;
        int            g, s, da, dw, db, last;
        for (int t = 0; t < 12; t++) begin
            req = NM'($urandom_range(1, 7));
            for (int m = 0; m < NM; m++) begin
                a[m] = ($urandom_range(0, 1) == 1) ? tbl[$urandom_range(0, 5)] : $urandom;
                AWADDR_M[m*AW +: AW] = a[m];
            end
            AWVALID_M = req;
            g = model_winner(req, ptr_model);
            s = model_slave(a[g]);
            da = $urandom_range(0, 3); dw = $urandom_range(0, 3); db = $urandom_range(0, 3);
            last = (da > dw) ? da : dw;
            tick();
            checks++; if (obs_rr !== expv(g, s, 1)) begin errors++; $display("FAIL rand_grant t%0d: got %h expected %h", t, obs_rr, expv(g, s, 1)); end
            for (int c = 0; c <= last; c++) begin
                AWVALID_M[g] = (c <= da);
                AWREADY_S = 9'($urandom);
                AWREADY_S[s] = (c == da) ? 1'b1 : ((c > da) ? AWREADY_S[s] : 1'b0);
                WVALID_M = NM'($urandom); WLAST_M = NM'($urandom);
                WVALID_M[g] = 1'b1; WLAST_M[g] = (c == dw);
                WREADY_S = 9'($urandom);
                WREADY_S[s] = (c == dw) ? 1'b1 : WREADY_S[s];
                tick();
                checks++; if (obs_rr !== expv(g, s, (c == last) ? 2 : 1)) begin errors++; $display("FAIL rand_addr t%0d c%0d: got %h expected %h", t, c, obs_rr, expv(g, s, (c == last) ? 2 : 1)); end
            end
            AWVALID_M[g] = 1'b0;
            AWREADY_S = '0; WREADY_S = '0; WVALID_M = '0; WLAST_M = '0;
            for (int c = 0; c <= db; c++) begin
                BVALID_S = 9'($urandom); BVALID_S[s] = 1'b1;
                BREADY_M = NM'($urandom); BREADY_M[g] = (c == db);
                tick();
                checks++; if (obs_rr !== expv(g, s, (c == db) ? 0 : 2)) begin errors++; $display("FAIL rand_resp t%0d c%0d: got %h expected %h", t, c, obs_rr, expv(g, s, (c == db) ? 0 : 2)); end
            end
            BVALID_S = '0; BREADY_M = '0;
            ptr_model = (g + 1) % NM;
        end
        clr_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_inputs();
        AWADDR_M = '0;
        test_reset();
        test_reset_mid_resp();
        test_single_write();
        test_decode();
        test_w_order();
        test_stalled_b();
        test_fairness();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
